fifo_rr_write_arbiter: RTL

//  Shares one 8-deep FIFO write port among NUM_REQ producers with round-robin fairness.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 40 ++++
 rtl/fifo_rr_write_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared sizing and state types for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after last_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               valid
);

    logic [NUM_REQ-1:0]   above_mask;
    logic [2*NUM_REQ-1:0] dbl_req;

    // Lower half holds requesters above last_ptr, upper half the full set, so the
    // lowest set bit of the concatenation is the wrapped round-robin winner.
    always_comb begin
        above_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            above_mask[i] = (IDX_W'(i) > last_ptr);
        end
        dbl_req = {req, req & above_mask};

        valid   = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            if (!valid && dbl_req[i]) begin
                valid   = 1'b1;
                gnt_idx = IDX_W'(i % NUM_REQ);
            end
        end

        gnt_oh = '0;
        if (valid) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional macro ARB_LOCK_EN adds a lock input for atomic multi-beat packets.
module fifo_rr_write_arbiter #(
    parameter int unsigned NUM_REQ    = fifo_arb_pkg::NUM_REQ,
    parameter int unsigned DATA_W     = fifo_arb_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = fifo_arb_pkg::FIFO_DEPTH,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef ARB_LOCK_EN
    input  logic                      lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [CNT_W-1:0]          fifo_count,
    output logic                      fifo_w_en,
    output logic [DATA_W-1:0]         fifo_datain,
    output logic                      busy
);

    import fifo_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 w_en_q, w_en_d;
    logic [DATA_W-1:0]    datain_q, datain_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 room;
    logic                 lock_in;
    logic                 keep_lock;

`ifdef ARB_LOCK_EN
    assign lock_in = lock;
`else
    assign lock_in = 1'b0;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .gnt_oh   (pick_oh),
        .gnt_idx  (pick_idx),
        .valid    (pick_valid)
    );

    // A registered write not yet seen in fifo_count still occupies a slot.
    assign room = ({1'b0, fifo_count} + (CNT_W+1)'(w_en_q)) < (CNT_W+1)'(FIFO_DEPTH);

    assign keep_lock = (state_q == LOCK) && req[last_ptr_q] && lock_in;

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        gnt_d      = '0;
        w_en_d     = 1'b0;
        datain_d   = datain_q;

        if (keep_lock) begin
            // Locked owner keeps the port; a no-room stall does not release it.
            if (room) begin
                gnt_d       = '0;
                gnt_d[last_ptr_q] = 1'b1;
                w_en_d      = 1'b1;
                datain_d    = req_data[last_ptr_q*DATA_W +: DATA_W];
            end
        end else begin
            state_d = ARB;
            if (room && pick_valid) begin
                gnt_d      = pick_oh;
                w_en_d     = 1'b1;
                datain_d   = req_data[pick_idx*DATA_W +: DATA_W];
                last_ptr_d = pick_idx;
                if (lock_in) begin
                    state_d = LOCK;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB;
            last_ptr_q <= IDX_W'(NUM_REQ - 1);
            gnt_q      <= '0;
            w_en_q     <= 1'b0;
            datain_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            gnt_q      <= gnt_d;
            w_en_q     <= w_en_d;
            datain_q   <= datain_d;
        end
    end

    assign gnt         = gnt_q;
    assign fifo_w_en   = w_en_q;
    assign fifo_datain = datain_q;
    assign busy        = (|req) | w_en_q;

endmodule
